// File: rtl/dtc_table_walker_if.sv
// Bundle of the feature-vector input stream, the result stream and the node-table write port
// that connects a dtc_table_walker to its producer, consumer and configuration master.
interface dtc_table_walker_if #(
    parameter int N_FEAT = 9,
    parameter int OUT_W  = 5,
    parameter int FI_W   = 4,
    parameter int AW     = 7
);
    localparam int NODE_W = 1 + FI_W + 2 * AW;

    // Both streams are strict valid/ready: a beat transfers on a rising edge where valid and ready
    // are both high; once raised, valid and its payload hold until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [N_FEAT-1:0] in_feat;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_class;
    logic              out_err;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NODE_W-1:0] cfg_data;
    logic              busy;

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_class, out_err, busy
    );

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_class, out_err, busy
    );
endinterface

// File: rtl/dtc_table_walker.sv
// Sequential decision-tree classifier: walks a writable node table one node per clock from the
// root and returns the leaf class, aborting with an error flag after MAX_DEPTH internal nodes.
module dtc_table_walker #(
    parameter int N_FEAT    = 9,
    parameter int OUT_W     = 5,
    parameter int FI_W      = 4,
    parameter int AW        = 7,
    parameter int MAX_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    dtc_table_walker_if.slave   bus,
    output logic [1:0]          dbg_state_o
);
    localparam int NODE_W  = 1 + FI_W + 2 * AW;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int TBL_N   = 1 << AW;
    localparam int FPAD_W  = 1 << FI_W;
    localparam logic [NODE_W-1:0] LEAF_CLASS0 = {1'b1, {(NODE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      addr_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [N_FEAT-1:0]  feat_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_class_q;
    logic               out_err_q;
    logic               busy_q;

    logic [NODE_W-1:0]  tbl_q [TBL_N];

    logic [NODE_W-1:0]  node_w;
    logic               node_leaf;
    logic [FI_W-1:0]    node_idx;
    logic [AW-1:0]      node_true;
    logic [AW-1:0]      node_false;
    logic [FPAD_W-1:0]  feat_pad;
    logic               feat_bit;
    logic [AW-1:0]      addr_d;
    logic               tbl_we_d;
    logic               depth_limit;

    always_comb begin
        node_w     = tbl_q[addr_q];
        node_leaf  = node_w[NODE_W-1];
        node_idx   = node_w[NODE_W-2 -: FI_W];
        node_true  = node_w[2*AW-1:AW];
        node_false = node_w[AW-1:0];
        // Zero-padding the feature vector makes out-of-range indices read as feature value 0.
        feat_pad              = '0;
        feat_pad[N_FEAT-1:0]  = feat_q;
        feat_bit              = feat_pad[node_idx];
        addr_d                = feat_bit ? node_true : node_false;
        depth_limit           = (depth_q == DEPTH_W'(MAX_DEPTH));
        tbl_we_d              = bus.cfg_we && (state_q == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= '{default: LEAF_CLASS0};
        end else if (tbl_we_d) begin
            tbl_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            depth_q     <= '0;
            feat_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        feat_q     <= bus.in_feat;
                        addr_q     <= '0;
                        depth_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_WALK;
                    end
                end
                S_WALK: begin
                    if (node_leaf) begin
                        out_class_q <= node_w[OUT_W-1:0];
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (depth_limit) begin
                        out_class_q <= '0;
                        out_err_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        addr_q  <= addr_d;
                        depth_q <= depth_q + DEPTH_W'(1);
                    end
                end
                S_DONE: begin
                    // in_ready rises together with the return to IDLE, so no re-accept this edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;
endmodule
